// File: rtl/branch_predict_unit.sv
// branch_predict_unit: RV32 branch resolution, 2-bit BHT predictor, redirect and statistics
module branch_predict_unit #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  lookup_pc,
    output logic             lookup_taken,
    input  logic             ex_valid,
    input  logic             ex_branch,
    input  logic             ex_kill,
    input  logic [2:0]       ex_funct3,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_target,
    input  logic [XLEN-1:0]  ex_rs1_val,
    input  logic [XLEN-1:0]  ex_rs2_val,
    input  logic             ex_pred_taken,
    output logic             res_valid,
    output logic             res_taken,
    output logic             res_illegal,
    output logic             mispredict,
    output logic [XLEN-1:0]  redirect_pc,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);
    localparam int IW = $clog2(BHT_ENTRIES);
    logic [1:0]    bht [BHT_ENTRIES];
    logic [IW-1:0] lookup_idx, ex_idx;
    logic          acc, illegal, eq, slt, ult, outcome, miss;
    logic [1:0]    cur, nxt;
    assign lookup_idx   = lookup_pc[IW+1:2];
    assign ex_idx       = ex_pc[IW+1:2];
    assign lookup_taken = bht[lookup_idx][1];
    assign acc          = ex_valid & ex_branch & ~ex_kill;
    assign illegal      = ex_funct3[2:1] == 2'b01;
    assign eq           = ex_rs1_val == ex_rs2_val;
    assign slt          = $signed(ex_rs1_val) < $signed(ex_rs2_val);
    assign ult          = ex_rs1_val < ex_rs2_val;
    always_comb begin
        outcome = 1'b0;
        case (ex_funct3)
            3'b000:  outcome = eq;
            3'b001:  outcome = ~eq;
            3'b100:  outcome = slt;
            3'b101:  outcome = ~slt;
            3'b110:  outcome = ult;
            3'b111:  outcome = ~ult;
            default: outcome = 1'b0;
        endcase
    end
    assign cur  = bht[ex_idx];
    assign nxt  = outcome ? ((cur == 2'd3) ? cur : cur + 2'd1) : ((cur == 2'd0) ? cur : cur - 2'd1);
    assign miss = acc & ~illegal & (outcome != ex_pred_taken);
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'd1;
            res_valid        <= 1'b0;
            res_taken        <= 1'b0;
            res_illegal      <= 1'b0;
            mispredict       <= 1'b0;
            redirect_pc      <= '0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            res_valid   <= acc;
            res_taken   <= acc & outcome;
            res_illegal <= acc & illegal;
            mispredict  <= miss;
            if (acc) redirect_pc <= outcome ? ex_target : ex_pc + XLEN'(4);
            if (acc && !illegal) begin
                bht[ex_idx]  <= nxt;
                branch_count <= branch_count + CNT_W'(1);
            end
            if (miss) mispredict_count <= mispredict_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: directed checks of branch resolution, BHT training and statistics
module tb_branch_predict_unit;
    logic        clk = 0, rst = 1;
    logic [31:0] lookup_pc = 0, ex_pc = 0, ex_target = 0, ex_rs1_val = 0, ex_rs2_val = 0;
    logic        ex_valid = 0, ex_branch = 0, ex_kill = 0, ex_pred_taken = 0;
    logic [2:0]  ex_funct3 = 0;
    logic        lookup_taken, res_valid, res_taken, res_illegal, mispredict;
    logic [31:0] redirect_pc, branch_count, mispredict_count;
    int          checks = 0, errors = 0;

    branch_predict_unit dut (
        .clk(clk), .rst(rst), .lookup_pc(lookup_pc), .lookup_taken(lookup_taken),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_kill(ex_kill), .ex_funct3(ex_funct3),
        .ex_pc(ex_pc), .ex_target(ex_target), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
        .ex_pred_taken(ex_pred_taken), .res_valid(res_valid), .res_taken(res_taken),
        .res_illegal(res_illegal), .mispredict(mispredict), .redirect_pc(redirect_pc),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] f3, input logic [31:0] pc, tgt, a, b, input logic p, k);
        ex_valid = 1; ex_branch = 1; ex_kill = k; ex_funct3 = f3;
        ex_pc = pc; ex_target = tgt; ex_rs1_val = a; ex_rs2_val = b; ex_pred_taken = p;
    endtask

    task automatic tick();
        @(posedge clk); #1;
        ex_valid = 0; ex_kill = 0;
    endtask

    task automatic outs(input string tag, input logic v, t, il, m, input logic [31:0] rpc);
        check({tag, ".valid"}, 32'(res_valid), 32'(v));
        check({tag, ".taken"}, 32'(res_taken), 32'(t));
        check({tag, ".illegal"}, 32'(res_illegal), 32'(il));
        check({tag, ".misp"}, 32'(mispredict), 32'(m));
        check({tag, ".rpc"}, redirect_pc, rpc);
    endtask

    task automatic cnts(input string tag, input logic [31:0] b, m);
        check({tag, ".bcnt"}, branch_count, b);
        check({tag, ".mcnt"}, mispredict_count, m);
    endtask

    initial begin
        // accepted taken branch presented during reset must be discarded
        drive(3'b000, 32'h300, 32'h500, 5, 5, 0, 0);
        @(posedge clk); #1;
        tick();
        rst = 0;
        outs("reset", 0, 0, 0, 0, 32'h0);
        cnts("reset", 0, 0);
        lookup_pc = 32'h100; #1;
        check("reset.lk100", 32'(lookup_taken), 0);
        lookup_pc = 32'h300; #1;
        check("reset.lk300", 32'(lookup_taken), 0);

        // six conditions with rs1=-1, rs2=1
        drive(3'b000, 32'h1000, 32'h2000, 32'hFFFFFFFF, 1, 0, 0); tick();
        outs("beq", 1, 0, 0, 0, 32'h1004);
        drive(3'b001, 32'h1000, 32'h2000, 32'hFFFFFFFF, 1, 0, 0); tick();
        outs("bne", 1, 1, 0, 1, 32'h2000);
        drive(3'b100, 32'h1000, 32'h2000, 32'hFFFFFFFF, 1, 0, 0); tick();
        outs("blt", 1, 1, 0, 1, 32'h2000);
        drive(3'b101, 32'h1000, 32'h2000, 32'hFFFFFFFF, 1, 0, 0); tick();
        outs("bge", 1, 0, 0, 0, 32'h1004);
        drive(3'b110, 32'h1000, 32'h2000, 32'hFFFFFFFF, 1, 0, 0); tick();
        outs("bltu", 1, 0, 0, 0, 32'h1004);
        drive(3'b111, 32'h1000, 32'h2000, 32'hFFFFFFFF, 1, 0, 0); tick();
        outs("bgeu", 1, 1, 0, 1, 32'h2000);
        cnts("cond", 6, 3);
        tick();
        outs("idle", 0, 0, 0, 0, 32'h2000);

        // train 0x200 (same index as 0x1000, left at weak-NT) with taken branches
        lookup_pc = 32'h200;
        drive(3'b000, 32'h200, 32'h180, 7, 7, 0, 0); #1;
        check("collide.old", 32'(lookup_taken), 0);
        tick();
        check("train1.lk", 32'(lookup_taken), 1);
        outs("train1", 1, 1, 0, 1, 32'h180);
        drive(3'b000, 32'h200, 32'h180, 7, 7, 1, 0); tick();
        outs("train2", 1, 1, 0, 0, 32'h180);
        drive(3'b000, 32'h200, 32'h180, 7, 7, 1, 0); tick();
        outs("train3", 1, 1, 0, 0, 32'h180);
        cnts("train", 9, 4);
        // saturated at 3: one not-taken keeps prediction taken, second drops it
        drive(3'b000, 32'h200, 32'h180, 7, 8, 1, 0); tick();
        check("sat.lk", 32'(lookup_taken), 1);
        outs("nt1", 1, 0, 0, 1, 32'h204);
        drive(3'b000, 32'h200, 32'h180, 7, 8, 1, 0); tick();
        check("nt2.lk", 32'(lookup_taken), 0);

        drive(3'b001, 32'hFFFFFFFC, 32'h40, 3, 3, 1, 0); tick();
        outs("wrap", 1, 0, 0, 1, 32'h0);
        cnts("wrap", 12, 7);

        // illegal funct3 with pred=1: no mispredict, no training, no counting
        drive(3'b010, 32'h200, 32'h180, 7, 7, 1, 0); tick();
        outs("illegal", 1, 0, 1, 0, 32'h204);
        cnts("illegal", 12, 7);
        drive(3'b011, 32'h200, 32'h180, 7, 8, 1, 0); tick();
        check("illegal011", 32'(res_illegal), 1);
        drive(3'b000, 32'h200, 32'h180, 7, 7, 0, 0); tick();
        check("post_illegal.lk", 32'(lookup_taken), 1);
        cnts("post_illegal", 13, 8);

        // killed taken branch: no outputs, no update, redirect holds
        drive(3'b000, 32'h200, 32'h900, 7, 7, 0, 1); tick();
        outs("kill", 0, 0, 0, 0, 32'h180);
        cnts("kill", 13, 8);
        drive(3'b000, 32'h200, 32'h180, 7, 8, 0, 0); tick();
        check("post_kill.lk", 32'(lookup_taken), 0);
        cnts("post_kill", 14, 8);

        // reset with an accepted branch restores everything
        rst = 1;
        drive(3'b000, 32'h200, 32'h180, 7, 7, 0, 0); tick();
        rst = 0;
        outs("rst2", 0, 0, 0, 0, 32'h0);
        cnts("rst2", 0, 0);
        check("rst2.lk", 32'(lookup_taken), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised, pipelined successor to the core's combinational branch-condition logic.
- Evaluates all six RV32 branch conditions for any XLEN, and registers the resolution one cycle after EX.
- Keeps a direct-mapped table of 2-bit saturating counters (BHT) that fetch reads for a taken/not-taken prediction.
- Detects mispredictions, produces the redirect PC, and keeps branch and misprediction statistics counters.

Parameters:
XLEN, 32, datapath/PC width in bits (>=32)
BHT_ENTRIES, 64, number of 2-bit counters; power of two, >=4
CNT_W, 32, width of statistics counters

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
lookup_pc  in  XLEN  fetch-stage PC to predict
lookup_taken  out  1  combinational prediction: MSB of BHT[idx(lookup_pc)]
ex_valid  in  1  EX-stage instruction valid
ex_branch  in  1  EX instruction is a conditional branch
ex_kill  in  1  EX instruction squashed; treated as ex_valid=0
ex_funct3  in  3  branch condition select
ex_pc  in  XLEN  PC of EX branch
ex_target  in  XLEN  computed branch target
ex_rs1_val  in  XLEN  operand 1
ex_rs2_val  in  XLEN  operand 2
ex_pred_taken  in  1  prediction fetch made for this branch
res_valid  out  1  registered: a branch resolved this cycle
res_taken  out  1  registered actual outcome
res_illegal  out  1  registered: funct3 was 010 or 011
mispredict  out  1  registered: redirect required
redirect_pc  out  XLEN  registered correct next PC
branch_count  out  CNT_W  resolved legal branches
mispredict_count  out  CNT_W  mispredictions

Behaviour:
- Index function: idx(pc) = pc[log2(BHT_ENTRIES)+1:2].
- Accept condition: acc = ex_valid & ex_branch & ~ex_kill.
- Condition evaluation, combinational on EX inputs:
  - 000 beq: equal.
  - 001 bne: not equal.
  - 100 blt: signed less-than.
  - 101 bge: signed greater-or-equal.
  - 110 bltu: unsigned less-than.
  - 111 bgeu: unsigned greater-or-equal.
  - 010/011: illegal, outcome 0.
  - All comparisons use full XLEN width.
- Latency: exactly 1 cycle. Outputs for the branch accepted at edge N are valid during cycle N+1.
- Registered outputs:
  - res_valid = acc.
  - res_taken = outcome.
  - res_illegal = acc & illegal.
  - mispredict = acc & ~illegal & (outcome != ex_pred_taken).
  - redirect_pc = outcome ? ex_target : ex_pc+4 (wraps mod 2^XLEN).
- Non-accept cycle: res_valid, res_taken, res_illegal and mispredict go to 0; redirect_pc holds its previous value.
- Illegal funct3:
  - No BHT update and no counter increment.
  - mispredict = 0 even if ex_pred_taken = 1; the trap path handles it.
- BHT update on the same edge as acceptance, legal branches only:
  - Taken: counter +1, saturating at 3.
  - Not taken: counter -1, saturating at 0.
  - Encoding: 0 strong-NT, 1 weak-NT, 2 weak-T, 3 strong-T.
- Read/write collision: lookup_pc and ex_pc map to the same index in one cycle → lookup_taken reflects the pre-update value; the new value is visible next cycle.
- Statistics counters:
  - branch_count increments on every accepted legal branch.
  - mispredict_count increments alongside mispredict.
  - Both wrap modulo 2^CNT_W without saturating.
- Reset, synchronous, takes priority over acceptance in the same cycle:
  - All BHT entries → 1 (weak not-taken), so lookup_taken = 0 everywhere.
  - All registered outputs → 0, redirect_pc → 0.
  - Both statistics counters → 0.
  - A branch presented during reset is discarded.
- Back-to-back accepts, one per cycle: full throughput. Two consecutive same-index branches see successive updates (the second uses the value written by the first).

Test Plan:
- Reset, then lookup_pc=0x100 → lookup_taken=0; all outputs 0; counters 0.
- Each funct3 with rs1=0xFFFFFFFF, rs2=0x00000001 → outcomes:
  - beq=0, bne=1.
  - blt=1, bge=0.
  - bltu=0, bgeu=1.
  - res_valid one cycle later.
- Branch ex_pc=0x200, target=0x180, taken, pred=0, accepted 3 times:
  - BHT[idx] goes 1→2→3→3, and lookup_taken at 0x200 turns 1 after the first accept.
  - mispredict=1 with redirect_pc=0x180 on the first accept only (pred=0); later accepts with pred=1 → mispredict=0.
  - mispredict_count=1, branch_count=3.
- Not-taken branch ex_pc=0xFFFFFFFC, pred=1 → redirect_pc=0x00000000 (wrap), mispredict=1.
- funct3=010, pred=1 → res_illegal=1, mispredict=0, BHT and counters unchanged.
- Edge cases:
  - ex_kill=1 with a valid branch → no outputs, no update.
  - rst asserted with an accepted branch → outputs 0 next cycle, BHT entries all 1.
  - Same-cycle lookup/update collision → old prediction returned.
